// File: rtl/adc_pkg.sv
// Shared ADC constants used by the result-path blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adc_pkg;

  // Width of one converted and averaged SAR result.
  localparam int ADC_RESULT_BITS = 12;

  // Default number of buffered results between the SAR controller and its consumer.
  localparam int ADC_FIFO_DEPTH = 8;

endpackage

// File: rtl/adc_fifo_mem.sv
// Result storage array: one synchronous write port, one asynchronous read port, no reset.
// Latency: write lands at the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the caller gates wr_en so dropped writes never touch the array.
module adc_fifo_mem #(
  parameter int DATA_BITS = 12,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Store one result per enabled edge; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_result_fifo.sv
// First-word-fall-through FIFO buffering SAR results, with sticky overflow and level interrupt.
// Latency: a result written into an empty FIFO is presented on rd_* the next cycle.
// Backpressure: rd_ready_in stalls the head; writes while full (no pop) are dropped and flagged.
module adc_result_fifo
  import adc_pkg::*;
#(
  parameter int DATA_BITS = ADC_RESULT_BITS,
  parameter int DEPTH     = ADC_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conv_finished_strobe_in,
  input  logic [DATA_BITS-1:0]     result_in,
  input  logic                     clear_in,
  input  logic [$clog2(DEPTH):0]   threshold_in,
  input  logic                     rd_ready_in,
  output logic                     rd_valid_out,
  output logic [DATA_BITS-1:0]     rd_data_out,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     overflow_out,
  output logic                     irq_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the fill level is a plain subtraction.
  logic [LW-1:0]        wr_ptr;
  logic [LW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [LW-1:0]        level_next;
  logic                 full;
  logic                 empty;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 drop;
  logic                 flush;
  logic                 mem_wr_en;
  logic [DATA_BITS-1:0] mem_rd_data;
  logic                 overflow_q;
  logic                 irq_q;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign flush = rst || clear_in;

  // A pop frees a slot in the same edge, so a write into a full FIFO
  // alongside a read is accepted rather than dropped.
  assign rd_fire   = !empty && rd_ready_in;
  assign wr_fire   = conv_finished_strobe_in && (!full || rd_fire);
  assign drop      = conv_finished_strobe_in && full && !rd_fire;
  assign mem_wr_en = wr_fire && !flush;

  // Fill level after this edge's traffic; feeds the registered interrupt.
  always_comb begin
    level_next = level;
    if (wr_fire && !rd_fire) begin
      level_next = level + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      level_next = level - 1'b1;
    end
  end

  // Pointer, sticky overflow and interrupt state; reset and clear both empty the FIFO.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      irq_q <= (threshold_in != '0) && (level_next >= threshold_in);
    end
  end

  adc_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr[PW-1:0]),
    .wr_data (result_in),
    .rd_addr (rd_ptr[PW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Uninitialised storage is masked so rd_data_out reads 0 whenever nothing is valid.
  assign rd_valid_out = !empty;
  assign rd_data_out  = rd_valid_out ? mem_rd_data : '0;
  assign level_out    = level;
  assign overflow_out = overflow_q;
  assign irq_out      = irq_q;

endmodule
